// File: rtl/demux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : demux_rr_sched
// Description : FIFO-buffered round-robin dispatcher for a 1-to-2 demux with
//               per-lane credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_rr_sched #(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dataIn,
    input  logic       validIn,
    output logic       readyIn,
    input  logic       creditRet0,
    input  logic       creditRet1,
    output logic [7:0] dataOut,
    output logic       validOut,
    output logic       selector,
    output logic       fifoEmpty,
    output logic       errOverflow,
    output logic       errCredit
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CRW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]  c_countFull = CW'(DEPTH);
    localparam logic [CRW-1:0] c_creditMax = CRW'(CREDITS);

    logic [7:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [CW-1:0]  r_count;
    logic [CRW-1:0] r_credit0;
    logic [CRW-1:0] r_credit1;
    logic           r_rr;
    logic [7:0]     r_dataOut;
    logic           r_validOut;
    logic           r_selector;
    logic           r_errOverflow;
    logic           r_errCredit;

    logic w_full;
    logic w_nonEmpty;
    logic w_push;
    logic w_pop;
    logic w_lane;
    logic w_dec0;
    logic w_dec1;
    logic w_satErr0;
    logic w_satErr1;

    assign w_full     = (r_count == c_countFull);
    assign w_nonEmpty = (r_count != '0);
    // Fullness is judged before any same-cycle pop, so a full FIFO never bypasses.
    assign w_push     = validIn && !w_full;

    always_comb begin
        w_pop  = 1'b0;
        w_lane = r_rr;
        if (w_nonEmpty) begin
            if ((r_rr ? r_credit1 : r_credit0) != '0) begin
                w_pop  = 1'b1;
                w_lane = r_rr;
            end else if ((r_rr ? r_credit0 : r_credit1) != '0) begin
                w_pop  = 1'b1;
                w_lane = !r_rr;
            end
        end
    end

    assign w_dec0    = w_pop && !w_lane;
    assign w_dec1    = w_pop && w_lane;
    assign w_satErr0 = creditRet0 && !w_dec0 && (r_credit0 == c_creditMax);
    assign w_satErr1 = creditRet1 && !w_dec1 && (r_credit1 == c_creditMax);

    function automatic logic [CRW-1:0] creditNext(
        input logic [CRW-1:0] cur,
        input logic           dec,
        input logic           ret
    );
        logic [CRW-1:0] nxt;
        nxt = cur;
        if (dec && !ret)
            nxt = cur - CRW'(1);
        else if (ret && !dec && (cur != c_creditMax))
            nxt = cur + CRW'(1);
        return nxt;
    endfunction

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= dataIn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_credit0     <= c_creditMax;
            r_credit1     <= c_creditMax;
            r_rr          <= 1'b0;
            r_dataOut     <= '0;
            r_validOut    <= 1'b0;
            r_selector    <= 1'b0;
            r_errOverflow <= 1'b0;
            r_errCredit   <= 1'b0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)
                r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            r_credit0 <= creditNext(r_credit0, w_dec0, creditRet0);
            r_credit1 <= creditNext(r_credit1, w_dec1, creditRet1);

            r_validOut <= w_pop;
            if (w_pop) begin
                r_dataOut  <= r_mem[r_rdPtr];
                r_selector <= w_lane;
                r_rr       <= !w_lane;
            end

            if (validIn && w_full)
                r_errOverflow <= 1'b1;
            if (w_satErr0 || w_satErr1)
                r_errCredit <= 1'b1;
        end
    end

    assign readyIn     = !w_full;
    assign fifoEmpty   = !w_nonEmpty;
    assign dataOut     = r_dataOut;
    assign validOut    = r_validOut;
    assign selector    = r_selector;
    assign errOverflow = r_errOverflow;
    assign errCredit   = r_errCredit;
endmodule
`default_nettype wire

// File: tb/tb_demux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_rr_sched
// Description : Directed, table-driven self-checking bench for demux_rr_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_rr_sched;
    logic       clk;
    logic       reset;
    logic [7:0] dataIn;
    logic       validIn;
    logic       readyIn;
    logic       creditRet0;
    logic       creditRet1;
    logic [7:0] dataOut;
    logic       validOut;
    logic       selector;
    logic       fifoEmpty;
    logic       errOverflow;
    logic       errCredit;

    int checks = 0;
    int errors = 0;

    demux_rr_sched #(.DEPTH(4), .CREDITS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .validIn    (validIn),
        .readyIn    (readyIn),
        .creditRet0 (creditRet0),
        .creditRet1 (creditRet1),
        .dataOut    (dataOut),
        .validOut   (validOut),
        .selector   (selector),
        .fifoEmpty  (fifoEmpty),
        .errOverflow(errOverflow),
        .errCredit  (errCredit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vIn;
        logic [7:0] dIn;
        logic       cr0;
        logic       cr1;
        logic       eValid;
        logic [7:0] eData;
        logic       eSel;
        logic       eReady;
        logic       eEmpty;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample 1 ns after the rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic c0, input logic c1,
                         input logic rst);
        @(negedge clk);
        validIn    = v;
        dataIn     = d;
        creditRet0 = c0;
        creditRet1 = c1;
        reset      = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] gotData [$];
        logic       gotSel  [$];
        logic [7:0] expData [4];
        logic       expSel  [4];

        reset = 1'b1; validIn = 1'b0; dataIn = '0; creditRet0 = 1'b0; creditRet1 = 1'b0;

        //           vIn  dIn    cr0   cr1   eVal  eData  eSel  eRdy  eEmpty
        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'hD4, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hD4, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hD4, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'hD4, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hD4, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD4, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1};

        // Reset state
        doReset();
        check("rst_validOut", int'(validOut), 0);
        check("rst_dataOut", int'(dataOut), 0);
        check("rst_selector", int'(selector), 0);
        check("rst_readyIn", int'(readyIn), 1);
        check("rst_fifoEmpty", int'(fifoEmpty), 1);
        check("rst_errOverflow", int'(errOverflow), 0);
        check("rst_errCredit", int'(errCredit), 0);
        check("rst_credit0", int'(dut.r_credit0), 2);
        check("rst_credit1", int'(dut.r_credit1), 2);

        // Round-robin dispatch and lane skip on zero credit
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].vIn, vecs[i].dIn, vecs[i].cr0, vecs[i].cr1, 1'b0);
            check($sformatf("vec%0d_validOut", i), int'(validOut), int'(vecs[i].eValid));
            check($sformatf("vec%0d_dataOut", i), int'(dataOut), int'(vecs[i].eData));
            check($sformatf("vec%0d_selector", i), int'(selector), int'(vecs[i].eSel));
            check($sformatf("vec%0d_readyIn", i), int'(readyIn), int'(vecs[i].eReady));
            check($sformatf("vec%0d_fifoEmpty", i), int'(fifoEmpty), int'(vecs[i].eEmpty));
            check($sformatf("vec%0d_errOverflow", i), int'(errOverflow), 0);
            check($sformatf("vec%0d_errCredit", i), int'(errCredit), 0);
            if (i == 4) begin
                check("t1_credit0_end", int'(dut.r_credit0), 0);
                check("t1_credit1_end", int'(dut.r_credit1), 0);
            end
        end
        check("t2_credit1_end", int'(dut.r_credit1), 0);

        // Overflow: six words, then three more into a stalled FIFO
        doReset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
            check($sformatf("t3_ready%0d", i), int'(readyIn), 1);
        end
        check("t3_count6", int'(dut.r_count), 2);
        cycle(1'b1, 8'h17, 1'b0, 1'b0, 1'b0);
        check("t3_ready7", int'(readyIn), 1);
        cycle(1'b1, 8'h18, 1'b0, 1'b0, 1'b0);
        check("t3_ready_full", int'(readyIn), 0);
        check("t3_errOv_before", int'(errOverflow), 0);
        cycle(1'b1, 8'h19, 1'b0, 1'b0, 1'b0);
        check("t3_errOv_after", int'(errOverflow), 1);
        check("t3_count_full", int'(dut.r_count), 4);
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 8'h00, (c == 0 || c == 3), (c == 0 || c == 3), 1'b0);
            if (validOut) begin
                gotData.push_back(dataOut);
                gotSel.push_back(selector);
            end
        end
        expData = '{8'h15, 8'h16, 8'h17, 8'h18};
        expSel  = '{1'b0, 1'b1, 1'b0, 1'b1};
        check("t3_drain_count", gotData.size(), 4);
        for (int i = 0; i < 4 && i < gotData.size(); i++) begin
            check($sformatf("t3_drain%0d_data", i), int'(gotData[i]), int'(expData[i]));
            check($sformatf("t3_drain%0d_sel", i), int'(gotSel[i]), int'(expSel[i]));
        end
        check("t3_empty_end", int'(fifoEmpty), 1);
        check("t3_errOv_sticky", int'(errOverflow), 1);

        // Credit return at saturation, and return coinciding with dispatch
        doReset();
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t4_errCredit", int'(errCredit), 1);
        check("t4_credit0_sat", int'(dut.r_credit0), 2);
        doReset();
        cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t4b_validOut", int'(validOut), 1);
        check("t4b_dataOut", int'(dataOut), 8'h42);
        check("t4b_selector", int'(selector), 0);
        check("t4b_credit0", int'(dut.r_credit0), 2);
        check("t4b_errCredit", int'(errCredit), 0);

        // Mid-operation reset with 3 words buffered and credits 1/0
        doReset();
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0, 1'b0);
        check("t5_errOv", int'(errOverflow), 1);
        check("t5_errCr", int'(errCredit), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t5_pop_data", int'(dataOut), 8'h25);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t5_pre_count", int'(dut.r_count), 3);
        check("t5_pre_credit0", int'(dut.r_credit0), 1);
        check("t5_pre_credit1", int'(dut.r_credit1), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t5_validOut", int'(validOut), 0);
        check("t5_fifoEmpty", int'(fifoEmpty), 1);
        check("t5_readyIn", int'(readyIn), 1);
        check("t5_errOv_clr", int'(errOverflow), 0);
        check("t5_errCr_clr", int'(errCredit), 0);
        check("t5_credit0", int'(dut.r_credit0), 2);
        check("t5_credit1", int'(dut.r_credit1), 2);
        cycle(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        check("t5_push_noval", int'(validOut), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t5_7E_valid", int'(validOut), 1);
        check("t5_7E_data", int'(dataOut), 8'h7E);
        check("t5_7E_sel", int'(selector), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
